// File: rtl/demod_frame_ctrl.sv
// demod_frame_ctrl
// Admits an exact number of demodulated I/Q samples after a software start,
// cuts them into fixed-length frames with a generated tlast, and isolates the
// upstream ready from downstream backpressure through a 2-entry skid buffer.
// Outside a capture, upstream samples are accepted, discarded and counted.
module demod_frame_ctrl #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int LEN_WIDTH              = 16
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_aresetn,
   input  logic                                s00_axis_tvalid,
   input  logic                                s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   output logic                                s00_axis_tready,
   input  logic                                m00_axis_tready,
   output logic                                m00_axis_tvalid,
   output logic                                m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   input  logic                                start,
   input  logic                                abort,
   input  logic [LEN_WIDTH-1:0]                frame_len,
   input  logic [LEN_WIDTH-1:0]                num_frames,
   output logic                                busy,
   output logic                                done,
   output logic [LEN_WIDTH-1:0]                frames_sent,
   output logic [LEN_WIDTH-1:0]                drop_count
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

   localparam int DW = C_S00_AXIS_TDATA_WIDTH;
   localparam int SW = C_S00_AXIS_TDATA_WIDTH / 8;
   localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] LenMax = '1;

   state_e               state_q, state_d;
   logic [1:0]           occ_q, occ_d, occMid;
   logic [DW-1:0]        data0_q, data0_d, data1_q, data1_d;
   logic [SW-1:0]        strb0_q, strb0_d, strb1_q, strb1_d;
   logic                 force0_q, force0_d, force1_q, force1_d;
   logic [LEN_WIDTH-1:0] frameLen_q, frameLen_d, numFrames_q, numFrames_d;
   logic [LEN_WIDTH-1:0] inBeat_q, inBeat_d, inFrame_q, inFrame_d;
   logic [LEN_WIDTH-1:0] outBeat_q, outBeat_d;
   logic [LEN_WIDTH-1:0] framesSent_q, framesSent_d, dropCount_q, dropCount_d;
   logic                 tready_q, tready_d, done_q, done_d;
   logic                 pushEn, popEn, discardEn, headLast;
   logic                 unusedTlast;

   // Upstream tlast carries no meaning here; frames are cut by our own counters.
   assign unusedTlast = s00_axis_tlast;

   assign pushEn    = (state_q == RUN) && s00_axis_tvalid && tready_q;
   assign discardEn = (state_q != RUN) && s00_axis_tvalid && tready_q;
   assign popEn     = (occ_q != 2'd0) && m00_axis_tready;
   // The head beat ends a frame either by count or because an abort forced it.
   assign headLast  = (occ_q != 2'd0) && (force0_q || (outBeat_q == frameLen_q - LenOne));

   assign s00_axis_tready = tready_q;
   assign m00_axis_tvalid = (occ_q != 2'd0);
   assign m00_axis_tlast  = headLast;
   assign m00_axis_tdata  = data0_q;
   assign m00_axis_tstrb  = strb0_q;
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign frames_sent     = framesSent_q;
   assign drop_count      = dropCount_q;

   // Next-state logic: skid buffer shift/fill, frame counters and sequencing.
   always_comb begin
      state_d      = state_q;
      data0_d      = data0_q;
      data1_d      = data1_q;
      strb0_d      = strb0_q;
      strb1_d      = strb1_q;
      force0_d     = force0_q;
      force1_d     = force1_q;
      frameLen_d   = frameLen_q;
      numFrames_d  = numFrames_q;
      inBeat_d     = inBeat_q;
      inFrame_d    = inFrame_q;
      outBeat_d    = outBeat_q;
      framesSent_d = framesSent_q;
      dropCount_d  = dropCount_q;
      done_d       = 1'b0;

      // Pop shifts the second entry to the head, then a push fills the first
      // free slot, which keeps order intact when both happen together.
      if (popEn) begin
         data0_d  = data1_q;
         strb0_d  = strb1_q;
         force0_d = force1_q;
         force1_d = 1'b0;
         if (headLast) begin
            outBeat_d    = '0;
            framesSent_d = framesSent_q + LenOne;
         end else begin
            outBeat_d = outBeat_q + LenOne;
         end
      end
      occMid = occ_q - {1'b0, popEn};
      if (pushEn) begin
         if (occMid == 2'd0) begin
            data0_d  = s00_axis_tdata;
            strb0_d  = s00_axis_tstrb;
            force0_d = 1'b0;
         end else begin
            data1_d  = s00_axis_tdata;
            strb1_d  = s00_axis_tstrb;
            force1_d = 1'b0;
         end
         if (inBeat_q == frameLen_q - LenOne) begin
            inBeat_d  = '0;
            inFrame_d = inFrame_q + LenOne;
            if ((numFrames_q != '0) && (inFrame_q == numFrames_q - LenOne)) begin
               state_d = FLUSH;
            end
         end else begin
            inBeat_d = inBeat_q + LenOne;
         end
      end
      occ_d = occMid + {1'b0, pushEn};

      if (discardEn && (dropCount_q != LenMax)) begin
         dropCount_d = dropCount_q + LenOne;
      end

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               frameLen_d   = (frame_len == '0) ? LenOne : frame_len;
               numFrames_d  = num_frames;
               inBeat_d     = '0;
               inFrame_d    = '0;
               outBeat_d    = '0;
               framesSent_d = '0;
               dropCount_d  = '0;
               state_d      = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               if (occ_d == 2'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = FLUSH;
                  if (occ_d == 2'd2) begin
                     force1_d = 1'b1;
                  end else begin
                     force0_d = 1'b1;
                  end
               end
            end
         end
         FLUSH: begin
            if (occ_d == 2'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      tready_d = (state_d != RUN) || (occ_d != 2'd2);
   end

   // State, buffer and all registered outputs; reset drops buffered samples.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q      <= IDLE;
         occ_q        <= 2'd0;
         data0_q      <= '0;
         data1_q      <= '0;
         strb0_q      <= '0;
         strb1_q      <= '0;
         force0_q     <= 1'b0;
         force1_q     <= 1'b0;
         frameLen_q   <= '0;
         numFrames_q  <= '0;
         inBeat_q     <= '0;
         inFrame_q    <= '0;
         outBeat_q    <= '0;
         framesSent_q <= '0;
         dropCount_q  <= '0;
         tready_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         data0_q      <= data0_d;
         data1_q      <= data1_d;
         strb0_q      <= strb0_d;
         strb1_q      <= strb1_d;
         force0_q     <= force0_d;
         force1_q     <= force1_d;
         frameLen_q   <= frameLen_d;
         numFrames_q  <= numFrames_d;
         inBeat_q     <= inBeat_d;
         inFrame_q    <= inFrame_d;
         outBeat_q    <= outBeat_d;
         framesSent_q <= framesSent_d;
         dropCount_q  <= dropCount_d;
         tready_q     <= tready_d;
         done_q       <= done_d;
      end
   end

endmodule
